// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux8
// Description : 8-slot TDM stream demultiplexer. Gathers a frame of eight
//               words and presents channels a..h in parallel, updated together.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux8 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic             frame_valid,
    output logic             locked,
    output logic [2:0]       slot,
    output logic             sync_err
);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state;
    // Slot 7 never needs a shadow: its word goes straight into h.
    logic [WIDTH-1:0] r_shadow [0:6];

    assign locked = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            slot        <= 3'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            a <= '0; b <= '0; c <= '0; d <= '0;
            e <= '0; f <= '0; g <= '0; h <= '0;
            for (int i = 0; i < 7; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                if (r_state == HUNT) begin
                    if (frame_start) begin
                        r_shadow[0] <= din;
                        slot        <= 3'd1;
                        r_state     <= RUN;
                    end
                end else if (frame_start && (slot != 3'd0)) begin
                    // Realign: drop the partial frame and restart from this word.
                    sync_err    <= 1'b1;
                    r_shadow[0] <= din;
                    slot        <= 3'd1;
                end else if (slot == 3'd7) begin
                    a <= r_shadow[0];
                    b <= r_shadow[1];
                    c <= r_shadow[2];
                    d <= r_shadow[3];
                    e <= r_shadow[4];
                    f <= r_shadow[5];
                    g <= r_shadow[6];
                    h <= din;
                    frame_valid <= 1'b1;
                    slot        <= 3'd0;
                end else begin
                    r_shadow[slot] <= din;
                    slot           <= slot + 3'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
